uart_reg_responder: RTL and testbench
=====================================

Name: uart_reg_responder

Overview:
- Host-side command responder on the user side of the UART top-level block.
- Receives 5-byte command frames from the receiver (uart_rx_data / uart_rx_flag) and executes a register write or read on an internal register bank.
- Sends a 5-byte reply frame through the transmitter (uart_trig / uart_tx_data / uart_tx_busy).
- Gives the board a UART-accessible control/status register file.

Parameters:
- REG_NUM, 16, number of 8-bit registers; valid addresses are 0..REG_NUM-1; legal range 1..256.
- TIMEOUT_CYC, 500000, maximum clk cycles allowed between consecutive bytes of one frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- uart_rx_data  input  8  received byte, valid while uart_rx_flag=1
- uart_rx_flag  input  1  one-cycle pulse per received byte
- uart_tx_busy  input  1  transmitter busy
- uart_trig  output  1  one-cycle pulse that launches a TX byte
- uart_tx_data  output  8  TX byte, held stable from trig until busy falls
- regs_flat  output  REG_NUM*8  register bank; reg i is at bits [8i+7:8i]
- wr_strobe  output  1  one-cycle pulse when a write commits
- wr_addr  output  8  address of the last committed write

Behaviour:
- Reset (async, rst=1): all registers 0; uart_trig=0; uart_tx_data=0; wr_strobe=0; wr_addr=0; FSM goes to IDLE.
  - Reset mid-frame or mid-reply aborts immediately. No further trig is issued.
- Command frame: 0xA5, CMD, ADDR, DATA, CHK.
  - CHK = CMD^ADDR^DATA.
  - CMD 0x01 = write. CMD 0x02 = read; DATA is don't-care but is still included in CHK.
- Reply frame: 0x5A, STAT, ADDR, RDATA, RCHK.
  - RCHK = STAT^ADDR^RDATA.
  - STAT: 0x00 OK, 0x01 bad checksum, 0x02 bad CMD, 0x03 ADDR >= REG_NUM.
  - RDATA is the register value on an OK read, the written value on an OK write, and 0x00 on any error.
- RX FSM states: IDLE → GET_CMD → GET_ADDR → GET_DATA → GET_CHK → EXEC → REPLY.
  - In IDLE, any byte other than 0xA5 is discarded.
  - Each uart_rx_flag pulse advances exactly one state.
- Inter-byte timeout: a counter clears on every byte.
  - If it reaches TIMEOUT_CYC in GET_* states, the frame is dropped, the FSM returns to IDLE, and no reply is sent.
- EXEC (1 cycle): error checks are evaluated in priority order checksum > CMD > ADDR.
  - An OK write updates the register and pulses wr_strobe on the same edge that updates wr_addr.
  - Register update is visible on regs_flat the cycle after EXEC.
  - An errored frame never modifies registers.
- REPLY sequences 5 bytes. For each byte:
  - TX_WAIT_IDLE: wait for busy=0.
  - TX_TRIG: drive uart_tx_data and pulse uart_trig for 1 cycle.
  - TX_WAIT_HI: wait for busy=1. The transmitter guarantees busy rises within 2 cycles of trig.
  - TX_WAIT_LO: wait for busy=0.
  - After byte 5, the FSM returns to IDLE.
- Latency: first trig occurs 2 cycles after the CHK byte's flag, provided busy=0.
- Bytes arriving during EXEC/REPLY are discarded, including 0xA5.
- A flag in the same cycle as a timeout expiry: the byte wins, and the timeout is ignored.

Optional Feature:
- Macro: UART_RESP_STAT_EN.
- When defined:
  - Adds output err_cnt[7:0], which increments by 1 on each errored frame (STAT≠0) and on each timeout drop, saturating at 0xFF.
  - Adds output frame_cnt[15:0], which counts replied frames and wraps.
  - Both reset to 0.
  - A read of address 0xFF returns STAT 0x00 with RDATA=err_cnt, bypassing the ADDR range check. A write to 0xFF returns STAT 0x03.
- When undefined: these ports and the counters are absent, and 0xFF is an ordinary address checked against REG_NUM.

Decomposition:
- Package uart_resp_pkg holds:
  - constants SOF_CMD=0xA5, SOF_RSP=0x5A;
  - CMD_WR=0x01, CMD_RD=0x02;
  - STAT_OK/STAT_CHK/STAT_CMD/STAT_ADDR;
  - the RX and TX state enumerations.
- One sub-module, uart_resp_tx_seq:
  - takes a 5-byte reply vector and a start pulse;
  - runs the trig/busy handshake;
  - returns a done pulse.

Test Plan:
- Write: frame A5 01 03 7E 7C → reply 5A 00 03 7E 7D; wr_strobe one pulse; wr_addr=0x03; regs_flat[31:24]=0x7E.
- Read after write: frame A5 02 03 00 01 → reply 5A 00 03 7E 7D; no wr_strobe.
- Bad checksum: frame A5 01 03 7E 00 → reply 5A 01 03 00 02; register 3 unchanged.
- Bad address (REG_NUM=16): frame A5 02 20 00 22 → reply 5A 03 20 00 23. Bad CMD: frame A5 07 01 00 06 → reply 5A 02 01 00 03.
- Timeout: send A5 01 02, then idle TIMEOUT_CYC+10 cycles → no trig. Then a full valid frame → normal reply, proving resync.
- Busy handshake and reset: hold busy high 1000 cycles before the reply → first trig 2 cycles after busy falls. Assert rst during the third reply byte → uart_trig stays 0 and registers read 0x00.

Source files
------------

// File: rtl/uart_resp_pkg.sv
// Shared constants, frame types and FSM encodings for the UART register responder.
package uart_resp_pkg;

    localparam logic [7:0] SOF_CMD   = 8'hA5;
    localparam logic [7:0] SOF_RSP   = 8'h5A;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] STAT_OK   = 8'h00;
    localparam logic [7:0] STAT_CHK  = 8'h01;
    localparam logic [7:0] STAT_CMD  = 8'h02;
    localparam logic [7:0] STAT_ADDR = 8'h03;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_GET_CMD,
        RX_GET_ADDR,
        RX_GET_DATA,
        RX_GET_CHK,
        RX_EXEC,
        RX_REPLY
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT_IDLE,
        TX_TRIG,
        TX_WAIT_HI,
        TX_WAIT_LO
    } tx_state_e;

    // Element 0 is the first byte on the wire.
    typedef logic [4:0][7:0] reply_t;

endpackage

// File: rtl/uart_resp_tx_seq.sv
// Sends a 5-byte reply through the UART transmitter using the trig/busy handshake.
module uart_resp_tx_seq
    import uart_resp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  reply_t     reply_i,
    input  logic       busy_i,
    output logic       trig_o,
    output logic [7:0] data_o,
    output logic       done_o
);

    tx_state_e  state_q, state_d;
    logic [2:0] idx_q, idx_d;
    reply_t     frame_q, frame_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= TX_IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        data_d  = data_q;
        done_o  = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    frame_d = reply_i;
                    idx_d   = '0;
                    // Skip the idle wait so the first trig costs no extra cycle.
                    if (!busy_i) begin
                        data_d  = reply_i[0];
                        state_d = TX_TRIG;
                    end else begin
                        state_d = TX_WAIT_IDLE;
                    end
                end
            end
            TX_WAIT_IDLE: begin
                if (!busy_i) begin
                    data_d  = frame_q[idx_q];
                    state_d = TX_TRIG;
                end
            end
            TX_TRIG: state_d = TX_WAIT_HI;
            TX_WAIT_HI: begin
                if (busy_i) state_d = TX_WAIT_LO;
            end
            TX_WAIT_LO: begin
                if (!busy_i) begin
                    if (idx_q == 3'd4) begin
                        done_o  = 1'b1;
                        state_d = TX_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = TX_WAIT_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign trig_o = (state_q == TX_TRIG);
    assign data_o = data_q;

endmodule

// File: rtl/uart_reg_responder.sv
// UART command responder: 5-byte frames read/write an 8-bit register bank.
// Define UART_RESP_STAT_EN to add err_cnt/frame_cnt and the 0xFF err_cnt read.
module uart_reg_responder
    import uart_resp_pkg::*;
#(
    parameter int REG_NUM     = 16,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           uart_rx_data,
    input  logic                 uart_rx_flag,
    input  logic                 uart_tx_busy,
    output logic                 uart_trig,
    output logic [7:0]           uart_tx_data,
    output logic [REG_NUM*8-1:0] regs_flat,
    output logic                 wr_strobe,
    output logic [7:0]           wr_addr
`ifdef UART_RESP_STAT_EN
    ,
    output logic [7:0]           err_cnt,
    output logic [15:0]          frame_cnt
`endif
);

    localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    rx_state_e                  state_q, state_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [7:0]                 cmd_q, addr_q, data_q, chk_q;
    logic [REG_NUM-1:0][7:0]    regs_q;
    logic                       wr_strobe_q;
    logic [7:0]                 wr_addr_q;
    logic [7:0]                 stat, rdata;
    logic                       chk_ok, addr_ok, exec, do_wr, drop, tx_done;
    reply_t                     reply;

`ifdef UART_RESP_STAT_EN
    logic [7:0]  err_cnt_q;
    logic [15:0] frame_cnt_q;
`endif

    assign exec    = (state_q == RX_EXEC);
    assign chk_ok  = ((cmd_q ^ addr_q ^ data_q) == chk_q);
    assign addr_ok = ({1'b0, addr_q} < 9'(REG_NUM));

    always_comb begin
        stat  = STAT_OK;
        rdata = 8'h00;
        if (!chk_ok) begin
            stat = STAT_CHK;
        end else if (cmd_q != CMD_WR && cmd_q != CMD_RD) begin
            stat = STAT_CMD;
`ifdef UART_RESP_STAT_EN
        end else if (addr_q == 8'hFF) begin
            if (cmd_q == CMD_RD) rdata = err_cnt_q;
            else                 stat  = STAT_ADDR;
`endif
        end else if (!addr_ok) begin
            stat = STAT_ADDR;
        end else if (cmd_q == CMD_WR) begin
            rdata = data_q;
        end else begin
            rdata = regs_q[addr_q[AW-1:0]];
        end
    end

    assign reply = {stat ^ addr_q ^ rdata, rdata, addr_q, stat, SOF_RSP};
    assign do_wr = exec && (stat == STAT_OK) && (cmd_q == CMD_WR);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        drop    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                tmo_d = '0;
                if (uart_rx_flag && uart_rx_data == SOF_CMD)
                    state_d = RX_GET_CMD;
            end
            RX_GET_CMD, RX_GET_ADDR, RX_GET_DATA, RX_GET_CHK: begin
                // A byte landing on the expiry cycle still counts.
                if (uart_rx_flag) begin
                    tmo_d   = '0;
                    state_d = rx_state_e'(state_q + 3'd1);
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = '0;
                    drop    = 1'b1;
                    state_d = RX_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RX_EXEC:  state_d = RX_REPLY;
            RX_REPLY: begin
                if (tx_done) state_d = RX_IDLE;
            end
            default:  state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            tmo_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            chk_q       <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            wr_strobe_q <= 1'b0;
            if (uart_rx_flag) begin
                if (state_q == RX_GET_CMD)  cmd_q  <= uart_rx_data;
                if (state_q == RX_GET_ADDR) addr_q <= uart_rx_data;
                if (state_q == RX_GET_DATA) data_q <= uart_rx_data;
                if (state_q == RX_GET_CHK)  chk_q  <= uart_rx_data;
            end
            if (do_wr) begin
                regs_q[addr_q[AW-1:0]] <= data_q;
                wr_strobe_q            <= 1'b1;
                wr_addr_q              <= addr_q;
            end
        end
    end

`ifdef UART_RESP_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (((exec && stat != STAT_OK) || drop) && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
            if (tx_done)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign err_cnt   = err_cnt_q;
    assign frame_cnt = frame_cnt_q;
`endif

    uart_resp_tx_seq u_tx_seq (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (exec),
        .reply_i (reply),
        .busy_i  (uart_tx_busy),
        .trig_o  (uart_trig),
        .data_o  (uart_tx_data),
        .done_o  (tx_done)
    );

    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: expected reply bytes are queued
// by the stimulus and popped by a monitor on every uart_trig.
module tb_uart_reg_responder;

    localparam int REG_NUM = 16;
    localparam int TMO     = 200;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           rx_data = 8'h00;
    logic                 rx_flag = 1'b0;
    logic                 hold_busy = 1'b0;
    logic                 model_busy = 1'b0;
    logic                 tx_busy;
    logic                 trig;
    logic [7:0]           tx_data;
    logic [REG_NUM*8-1:0] regs_flat;
    logic                 wr_strobe;
    logic [7:0]           wr_addr;
`ifdef UART_RESP_STAT_EN
    logic [7:0]           err_cnt;
    logic [15:0]          frame_cnt;
`endif

    int total = 0;
    int passed = 0;
    int trig_cnt = 0;
    int strobe_cnt = 0;
    logic [7:0] exp_q[$];

    assign tx_busy = hold_busy | model_busy;

    uart_reg_responder #(.REG_NUM(REG_NUM), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_data (rx_data),
        .uart_rx_flag (rx_flag),
        .uart_tx_busy (tx_busy),
        .uart_trig    (trig),
        .uart_tx_data (tx_data),
        .regs_flat    (regs_flat),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr)
`ifdef UART_RESP_STAT_EN
        ,
        .err_cnt      (err_cnt),
        .frame_cnt    (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every trig must match the next queued reply byte.
    always @(negedge clk) begin
        if (trig) begin
            trig_cnt++;
            if (exp_q.size() == 0) check("spurious trig", 32'(trig), 32'd0);
            else check("reply byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        if (wr_strobe) strobe_cnt++;
    end

    // Transmitter model: busy rises right after trig and lasts 6 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (trig && !rst) begin
                model_busy = 1'b1;
                repeat (6) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge clk);
        rx_flag = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    task automatic push_reply(input logic [7:0] s, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(8'h5A);
        exp_q.push_back(s);
        exp_q.push_back(a);
        exp_q.push_back(d);
        exp_q.push_back(s ^ a ^ d);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reply drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int t0;
        int lat;
        int n;
        repeat (3) @(negedge clk);
        check("reset trig", 32'(trig), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset regs", 32'(regs_flat == '0), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write reg 3, also timing the first trig from the CHK flag.
        push_reply(8'h00, 8'h03, 8'h7E);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h7E);
        send_byte(8'h7C);
        @(negedge clk);
        check("first trig latency", 32'(trig), 32'd1);
        drain();
        check("write strobes", 32'(strobe_cnt), 32'd1);
        check("write wr_addr", 32'(wr_addr), 32'h03);
        check("write reg3", 32'(regs_flat[31:24]), 32'h7E);

        push_reply(8'h00, 8'h03, 8'h7E);
        send_frame(8'h02, 8'h03, 8'h00, 8'h01);
        drain();
        check("read no strobe", 32'(strobe_cnt), 32'd1);

        push_reply(8'h01, 8'h03, 8'h00);
        send_frame(8'h01, 8'h03, 8'h7E, 8'h00);
        drain();
        check("badchk reg3 kept", 32'(regs_flat[31:24]), 32'h7E);
        check("badchk no strobe", 32'(strobe_cnt), 32'd1);

        push_reply(8'h03, 8'h20, 8'h00);
        send_frame(8'h02, 8'h20, 8'h00, 8'h22);
        drain();

        push_reply(8'h02, 8'h01, 8'h00);
        send_frame(8'h07, 8'h01, 8'h00, 8'h06);
        drain();

`ifndef UART_RESP_STAT_EN
        push_reply(8'h03, 8'hFF, 8'h00);
        send_frame(8'h02, 8'hFF, 8'h00, 8'hFD);
        drain();
`endif

        // Partial frame then silence: dropped without a reply.
        t0 = trig_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (TMO + 10) @(negedge clk);
        check("timeout no trig", 32'(trig_cnt), 32'(t0));
        push_reply(8'h00, 8'h05, 8'h33);
        send_frame(8'h01, 8'h05, 8'h33, 8'h37);
        drain();
        check("resync reg5", 32'(regs_flat[47:40]), 32'h33);
        check("resync strobes", 32'(strobe_cnt), 32'd2);

        // Transmitter held busy before the reply.
        hold_busy = 1'b1;
        push_reply(8'h00, 8'h05, 8'h33);
        send_frame(8'h02, 8'h05, 8'h00, 8'h07);
        t0 = trig_cnt;
        repeat (1000) @(negedge clk);
        check("no trig while busy", 32'(trig_cnt), 32'(t0));
        hold_busy = 1'b0;
        lat = 0;
        while (!trig && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        check("trig after busy falls", 32'(lat >= 1 && lat <= 2), 32'd1);
        drain();

        // Reset during the third reply byte.
        push_reply(8'h00, 8'h09, 8'hAA);
        send_frame(8'h01, 8'h09, 8'hAA, 8'hA2);
        n = 0;
        while (exp_q.size() > 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("third byte reached", 32'(exp_q.size()), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        t0 = trig_cnt;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("no trig after reset", 32'(trig_cnt), 32'(t0));
        check("regs cleared", 32'(regs_flat == '0), 32'd1);
        check("wr_addr cleared", 32'(wr_addr), 32'd0);
        check("tx_data cleared", 32'(tx_data), 32'd0);
        push_reply(8'h00, 8'h09, 8'h00);
        send_frame(8'h02, 8'h09, 8'h00, 8'h0B);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
